// File: rtl/tss_pkg.sv
// tss_pkg: shared TSS stream types, widths and the round-robin pick helper.
package tss_pkg;
  localparam int TSS_AXIS_WIDTH = 8;
  localparam int RR_MAX_SRC = 8;
  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;
  // First set bit of req searching ptr, ptr+1, ... modulo n; result is one-hot.
  function automatic logic [RR_MAX_SRC-1:0] rr_pick(input logic [RR_MAX_SRC-1:0] req, input logic [2:0] ptr, input int n);
    int idx;
    rr_pick = '0;
    for (int k = RR_MAX_SRC - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && req[idx[2:0]]) rr_pick = RR_MAX_SRC'(1) << idx;
    end
  endfunction
endpackage

// File: rtl/tss_axis_arbiter_picker.sv
// tss_rr_picker: combinational round-robin priority encoder, one-hot plus index.
module tss_rr_picker
  import tss_pkg::*;
#(
  parameter int N_SRC = 2,
  localparam int PW = $clog2(N_SRC > 1 ? N_SRC : 2)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_SRC-1:0] grant,
  output logic [PW-1:0]    grant_idx
);
  always_comb begin
    grant = N_SRC'(rr_pick(RR_MAX_SRC'(req), 3'(ptr), N_SRC));
    grant_idx = '0;
    for (int i = 0; i < N_SRC; i++) if (grant[i]) grant_idx = PW'(i);
  end
endmodule

// File: rtl/tss_axis_arbiter.sv
// tss_axis_arbiter: packet-level round-robin merge of N_SRC TSS byte streams with stall watchdog.
module tss_axis_arbiter
  import tss_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int DATA_WIDTH = TSS_AXIS_WIDTH,
  parameter int STALL_TIMEOUT = 256,
  parameter int CNT_WIDTH = 16,
  localparam int SW = $clog2(N_SRC > 1 ? N_SRC : 2)
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic [N_SRC*DATA_WIDTH-1:0] s_tss_axis_tdata,
  input  logic [N_SRC-1:0]            s_tss_axis_tvalid,
  input  logic [N_SRC-1:0]            s_tss_axis_tlast,
  output logic [N_SRC-1:0]            s_tss_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_tss_axis_tdata,
  output logic                        m_tss_axis_tvalid,
  output logic                        m_tss_axis_tlast,
  input  logic                        m_tss_axis_tready,
  output logic [N_SRC-1:0]            grant_o,
  output logic                        busy_o,
  output logic                        stall_err_o,
  output logic [SW-1:0]               stall_src_o,
  output logic [CNT_WIDTH-1:0]        pkt_cnt_o
);
  localparam int WW = $clog2(STALL_TIMEOUT);
  arb_state_t       state;
  logic [SW-1:0]    g, rr_ptr, pick_idx, g_next;
  logic [N_SRC-1:0] pick;
  logic [WW-1:0]    wd_cnt;
  logic             lock, src_valid, src_last;
  tss_rr_picker #(.N_SRC(N_SRC)) u_picker (
    .req       (s_tss_axis_tvalid),
    .ptr       (rr_ptr),
    .grant     (pick),
    .grant_idx (pick_idx)
  );
  always_comb begin
    lock = state == ARB_LOCK;
    src_valid = s_tss_axis_tvalid[g];
    src_last = s_tss_axis_tlast[g];
    m_tss_axis_tvalid = lock && src_valid;
    m_tss_axis_tlast = lock && src_last;
    m_tss_axis_tdata = lock ? s_tss_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH] : '0;
    s_tss_axis_tready = lock ? N_SRC'(m_tss_axis_tready) << g : '0;
    g_next = (g == SW'(N_SRC - 1)) ? '0 : g + 1'b1;
    busy_o = lock;
  end
  always_ff @(posedge clk) begin
    if (arst) begin
      state <= ARB_IDLE;
      grant_o <= '0;
      g <= '0;
      rr_ptr <= '0;
      wd_cnt <= '0;
      pkt_cnt_o <= '0;
      stall_err_o <= 1'b0;
      stall_src_o <= '0;
    end else begin
      stall_err_o <= 1'b0;
      if (!lock) begin
        if (|s_tss_axis_tvalid) begin
          state <= ARB_LOCK;
          grant_o <= pick;
          g <= pick_idx;
          wd_cnt <= '0;
        end
      end else if (src_valid && m_tss_axis_tready && src_last) begin
        state <= ARB_IDLE;
        grant_o <= '0;
        rr_ptr <= g_next;
        pkt_cnt_o <= pkt_cnt_o + 1'b1;
      end else if (src_valid) begin
        wd_cnt <= '0;
      end else if (wd_cnt == WW'(STALL_TIMEOUT - 1)) begin
        // Revoke only happens with tvalid low, so the downstream never sees a beat vanish.
        state <= ARB_IDLE;
        grant_o <= '0;
        rr_ptr <= g_next;
        stall_err_o <= 1'b1;
        stall_src_o <= g;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tss_axis_arbiter.sv
// tb_tss_axis_arbiter: scoreboard bench for tss_axis_arbiter with a packet-level reference model.
module tb_tss_axis_arbiter;
  localparam int N = 2, DW = 8, ST = 8, CW = 4;
  logic clk = 0, arst = 1;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0] s_tvalid, s_tlast, s_tready, grant_o;
  logic [DW-1:0] m_tdata;
  logic m_tvalid, m_tlast, m_tready, busy_o, stall_err_o;
  logic [0:0] stall_src_o;
  logic [CW-1:0] pkt_cnt_o;
  always #5 clk = ~clk;
  tss_axis_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .STALL_TIMEOUT(ST), .CNT_WIDTH(CW)) dut (
    .clk(clk), .arst(arst),
    .s_tss_axis_tdata(s_tdata), .s_tss_axis_tvalid(s_tvalid), .s_tss_axis_tlast(s_tlast),
    .s_tss_axis_tready(s_tready),
    .m_tss_axis_tdata(m_tdata), .m_tss_axis_tvalid(m_tvalid), .m_tss_axis_tlast(m_tlast),
    .m_tss_axis_tready(m_tready),
    .grant_o(grant_o), .busy_o(busy_o), .stall_err_o(stall_err_o), .stall_src_o(stall_src_o),
    .pkt_cnt_o(pkt_cnt_o)
  );
  int errors = 0, checks = 0, dut_stalls = 0;
  logic [8:0] bq[N][$];
  int gap[N];
  logic [N-1:0] hs = '0;
  int gap_en = 0, rdy_mode = 0;
  logic rdy_script[$];
  logic m_locked = 0, m_serr = 0;
  int m_g = 0, m_rr = 0, m_idle = 0, m_cnt = 0, m_ssrc = 0;
  logic [8:0] exp_q[$];
  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask
  task automatic push_pkt(input int s, input int len, input int base, input bit trunc);
    for (int k = 0; k < len; k++) bq[s].push_back({1'(k == len - 1 && !trunc), 8'(base + k)});
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((bq[0].size() != 0 || bq[1].size() != 0 || m_locked) && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain_within_budget", int'(n < 3000), 1);
    repeat (2) @(posedge clk);
    #2;
  endtask
  task automatic pulse_rst();
    @(posedge clk); #1 arst = 1;
    @(posedge clk); #1 arst = 0;
    #1;
  endtask
  // Sources: hold tvalid until accepted, optional random gaps before each beat.
  initial begin
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1;
    for (int i = 0; i < N; i++) gap[i] = 0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          void'(bq[i].pop_front());
          s_tvalid[i] = 0;
          gap[i] = gap_en != 0 ? int'($urandom_range(0, 3)) : 0;
        end
        if (bq[i].size() == 0) s_tvalid[i] = 0;
        else if (!s_tvalid[i]) begin
          if (gap[i] > 0) gap[i]--;
          else s_tvalid[i] = 1;
        end
        s_tdata[i*DW +: DW] = bq[i].size() != 0 ? bq[i][0][7:0] : 8'h00;
        s_tlast[i] = bq[i].size() != 0 ? bq[i][0][8] : 1'b0;
      end
      m_tready = rdy_script.size() != 0 ? rdy_script.pop_front() : (rdy_mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end
  initial forever begin
    @(negedge clk);
    hs = s_tvalid & s_tready & {N{~arst}};
  end
  // Reference model: which source owns the channel, what it still owes, and the packet/stall bookkeeping.
  initial forever begin
    @(posedge clk);
    if (arst) begin
      m_locked = 0; m_rr = 0; m_idle = 0; m_cnt = 0; m_serr = 0; m_ssrc = 0;
      exp_q.delete();
    end else begin
      m_serr = 0;
      if (!m_locked) begin
        for (int k = 0; k < N; k++)
          if (!m_locked && s_tvalid[(m_rr + k) % N]) begin
            m_g = (m_rr + k) % N;
            m_locked = 1;
          end
        if (m_locked) begin
          m_idle = 0;
          for (int j = 0; j < bq[m_g].size(); j++) begin
            exp_q.push_back(bq[m_g][j]);
            if (bq[m_g][j][8]) break;
          end
        end
      end else if (s_tvalid[m_g] && m_tready && s_tlast[m_g]) begin
        m_locked = 0;
        m_rr = (m_g + 1) % N;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end else if (s_tvalid[m_g]) begin
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == ST) begin
          m_locked = 0; m_serr = 1; m_ssrc = m_g;
          m_rr = (m_g + 1) % N;
          exp_q.delete();
        end
      end
    end
  end
  // Monitor: compare visible state every cycle and pop expected beats on each transfer.
  logic prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic [8:0] e;
  initial forever begin
    @(negedge clk);
    chk("grant_o", int'(grant_o), m_locked ? (1 << m_g) : 0);
    chk("busy_o", int'(busy_o), int'(m_locked));
    chk("pkt_cnt_o", int'(pkt_cnt_o), m_cnt);
    chk("stall_err_o", int'(stall_err_o), int'(m_serr));
    chk("stall_src_o", int'(stall_src_o), m_ssrc);
    chk("s_tready", int'(s_tready), (m_locked && m_tready) ? (1 << m_g) : 0);
    chk("m_tvalid", int'(m_tvalid), int'(m_locked && s_tvalid[m_g]));
    if (stall_err_o) dut_stalls++;
    if (prev_stall && m_tvalid) chk("tdata_held", int'(m_tdata), int'(prev_data));
    prev_stall = m_tvalid && !m_tready;
    prev_data = m_tdata;
    if (m_tvalid && m_tready) begin
      chk("beat_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tdata", int'(m_tdata), int'(e[7:0]));
        chk("tlast", int'(m_tlast), int'(e[8]));
      end
    end
  end
  int s0;
  initial begin
    repeat (3) @(posedge clk);
    #1 arst = 0;
    @(posedge clk); #2;
    push_pkt(0, 3, 'hA1, 0);
    drain();
    pulse_rst();
    for (int p = 0; p < 2; p++) begin
      push_pkt(0, 2, 'h10 + 4 * p, 0);
      push_pkt(1, 2, 'h20 + 4 * p, 0);
    end
    drain();
    push_pkt(1, 4, 'h30, 0);
    rdy_script = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    drain();
    s0 = dut_stalls;
    push_pkt(0, 1, 'h40, 1);
    repeat (2) @(posedge clk);
    #2 push_pkt(1, 2, 'h50, 0);
    drain();
    chk("stall_pulses", dut_stalls - s0, 1);
    push_pkt(0, 4, 'h60, 0);
    push_pkt(1, 2, 'h70, 0);
    for (int n = 0; n < 50 && !busy_o; n++) @(negedge clk);
    @(posedge clk); #1 arst = 1;
    @(posedge clk); #1 arst = 0;
    drain();
    pulse_rst();
    for (int p = 0; p < 17; p++) push_pkt(0, 1, 'h80 + p, 0);
    drain();
    @(negedge clk);
    chk("pkt_cnt_wrap", int'(pkt_cnt_o), 1);
    gap_en = 1;
    rdy_mode = 1;
    repeat (60) push_pkt(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 5)), int'($urandom), 0);
    drain();
    @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
